// File: rtl/lcd_cmd_seq.sv
// Command-side initiator for the LCD controller: walks a command ROM, issues each command over
// the cmd/cmd_valid/busy handshake, then sums the 64-byte IRB write-back stream.
module lcd_cmd_seq #(
  parameter int unsigned CMD_AW  = 6,
  parameter int unsigned NUM_CMD = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  output logic              CROM_EN,
  output logic [CMD_AW-1:0] CROM_A,
  input  logic [2:0]        CROM_Q,
  output logic [2:0]        cmd,
  output logic              cmd_valid,
  input  logic              busy,
  input  logic              done,
  input  logic              IRB_RW,
  input  logic [5:0]        IRB_A,
  input  logic [7:0]        IRB_D,
  output logic              seq_done,
  output logic [13:0]       checksum,
  output logic              err
);

  localparam int unsigned IDX_W = CMD_AW + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W = 7;
  localparam int unsigned SUM_W = 14;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_CMD);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_RDQ,
    S_WAIT_RDY,
    S_ISSUE,
    S_HOLD,
    S_AUTOW,
    S_WAIT_DONE,
    S_FIN
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [2:0]       cmd_r, cmd_r_n;
  logic [CNT_W-1:0] exp_a, exp_a_n;
  logic [TMO_W-1:0] tmo, tmo_n;
  logic [SUM_W-1:0] checksum_n;
  logic             err_n;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state and datapath next values; tmo defaults to zero so every state entry clears it
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    cmd_r_n    = cmd_r;
    exp_a_n    = exp_a;
    tmo_n      = '0;
    checksum_n = checksum;
    err_n      = err;
    case (state)
      S_IDLE:  state_n = S_FETCH;
      S_FETCH: state_n = S_RDQ;
      S_RDQ: begin
        cmd_r_n = CROM_Q;
        state_n = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (!busy) begin
          state_n = S_ISSUE;
        end else if (tmo == TMO_LAST) begin
          err_n   = 1'b1;
          state_n = S_FIN;
        end else begin
          tmo_n = tmo + TMO_W'(1);
        end
      end
      S_ISSUE: begin
        idx_n   = idx + IDX_W'(1);
        state_n = S_HOLD;
      end
      // Controller busy lags cmd_valid by a cycle, so busy is not looked at here
      S_HOLD: begin
        if (cmd_r == 3'd0)     state_n = S_WAIT_DONE;
        else if (idx == IDX_END) state_n = S_AUTOW;
        else                   state_n = S_FETCH;
      end
      S_AUTOW: begin
        cmd_r_n = 3'd0;
        state_n = S_WAIT_RDY;
      end
      S_WAIT_DONE: begin
        // Only the next expected address counts; out-of-order writes are silently skipped
        if (!IRB_RW && (IRB_A == exp_a[5:0]) && !exp_a[CNT_W-1]) begin
          checksum_n = checksum + SUM_W'(IRB_D);
          exp_a_n    = exp_a + CNT_W'(1);
        end
        if (done) begin
          if (!exp_a_n[CNT_W-1]) err_n = 1'b1;
          state_n = S_FIN;
        end else if (tmo == TMO_LAST) begin
          err_n   = 1'b1;
          state_n = S_FIN;
        end else begin
          tmo_n = tmo + TMO_W'(1);
        end
      end
      S_FIN:   state_n = S_FIN;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath and registered outputs, driven from the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      cmd_r     <= '0;
      exp_a     <= '0;
      tmo       <= '0;
      CROM_EN   <= 1'b0;
      CROM_A    <= '0;
      cmd       <= '0;
      cmd_valid <= 1'b0;
      seq_done  <= 1'b0;
      checksum  <= '0;
      err       <= 1'b0;
    end else begin
      idx       <= idx_n;
      cmd_r     <= cmd_r_n;
      exp_a     <= exp_a_n;
      tmo       <= tmo_n;
      checksum  <= checksum_n;
      err       <= err_n;
      CROM_EN   <= (state_n == S_FETCH);
      cmd_valid <= (state_n == S_ISSUE);
      seq_done  <= seq_done | (state_n == S_FIN);
      if (state_n == S_FETCH) CROM_A <= idx[CMD_AW-1:0];
      if (state_n == S_ISSUE) cmd <= cmd_r;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Bench for lcd_cmd_seq: ROM and LCD controller models, table vectors, corner sequences and
// randomized lists checked against a list/sum reference model.
module tb_lcd_cmd_seq;

  localparam int CMD_AW  = 6;
  localparam int NUM_CMD = 16;
  localparam int TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        CROM_EN;
  logic [5:0]  CROM_A;
  logic [2:0]  CROM_Q;
  logic [2:0]  cmd;
  logic        cmd_valid;
  logic        busy;
  logic        done;
  logic        IRB_RW;
  logic [5:0]  IRB_A;
  logic [7:0]  IRB_D;
  logic        seq_done;
  logic [13:0] checksum;
  logic        err;

  lcd_cmd_seq #(.CMD_AW(CMD_AW), .NUM_CMD(NUM_CMD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .CROM_EN(CROM_EN), .CROM_A(CROM_A), .CROM_Q(CROM_Q),
    .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
    .IRB_RW(IRB_RW), .IRB_A(IRB_A), .IRB_D(IRB_D),
    .seq_done(seq_done), .checksum(checksum), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [2:0] rom [64];
  int         data [80];
  int         busy_len, gap, n_wr;

  typedef logic [2:0] cq_t [$];

  typedef struct packed {
    logic [23:0] head;
    logic [2:0]  fill;
    int          busy_len;
    int          gap;
    int          n_wr;
    int          dmode;
    int          exp_pulses;
    int          exp_sum;
    int          exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Command list: entries up to and including the first write; an implicit write if none
  function automatic cq_t model_cmds();
    cq_t q;
    for (int i = 0; i < NUM_CMD; i++) begin
      q.push_back(rom[i]);
      if (rom[i] == 3'd0) return q;
    end
    q.push_back(3'd0);
    return q;
  endfunction

  function automatic int model_sum();
    int s = 0;
    for (int i = 0; i < n_wr && i < 64; i++) s += data[i];
    return s;
  endfunction

  task automatic do_reset();
    reset = 1'b0; busy = 1'b0; done = 1'b0; IRB_RW = 1'b1; IRB_A = '0; IRB_D = '0; CROM_Q = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs one full sequence with the ROM/controller models; abort_wr>0 returns mid write-back
  task automatic run_scen(input string tag, input int exp_pulses, input int exp_sum,
                          input int exp_err, input int abort_wr);
    cq_t        exp_q;
    cq_t        got_q;
    logic [2:0] pend = '0;
    bit         pend_v = 1'b0, prev_v = 1'b0, wr_on = 1'b0;
    int         viol = 0, busy_cnt = 0, wr_wait = 0, wr_idx = 0, fin_at = -1, r;
    exp_q = model_cmds();
    do_reset();
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      CROM_Q = pend_v ? pend : 3'($urandom);
      pend_v = (CROM_EN === 1'b1);
      pend   = rom[CROM_A];
      IRB_RW = 1'b1; done = 1'b0; IRB_A = 6'($urandom); IRB_D = 8'($urandom);
      if (wr_on) begin
        if (wr_wait > 0) wr_wait--;
        else if (wr_idx < n_wr) begin
          r = $urandom_range(0, 7);
          if (r == 1) begin
            IRB_RW = 1'b0;
            IRB_A  = 6'(wr_idx + 1 + $urandom_range(0, 62));
          end else if (r > 1) begin
            IRB_RW = 1'b0;
            IRB_A  = 6'(wr_idx);
            IRB_D  = 8'(data[wr_idx]);
            wr_idx++;
          end
        end else begin
          done  = 1'b1;
          wr_on = 1'b0;
        end
      end
      if (cmd_valid === 1'b1) begin
        if (prev_v || seq_done !== 1'b0) viol++;
        got_q.push_back(cmd);
        busy_cnt = busy_len;
        if (cmd == 3'd0) begin
          wr_on   = 1'b1;
          wr_wait = gap;
        end
      end
      prev_v = (cmd_valid === 1'b1);
      busy   = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      if (abort_wr > 0 && wr_idx >= abort_wr) return;
      if (seq_done === 1'b1 && fin_at < 0) fin_at = cyc;
      if (fin_at >= 0 && cyc >= fin_at + 6) break;
    end
    check({tag, " seq_done"}, 32'(seq_done), 1);
    check({tag, " err"}, 32'(err), exp_err);
    check({tag, " checksum"}, 32'(checksum), exp_sum);
    check({tag, " pulses"}, got_q.size(), exp_pulses);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s cmd[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, " handshake_viol"}, viol, 0);
  endtask

  initial begin
    cq_t mq;
    bit  seen;
    int  pulses, v;

    vecs[0] = '{24'o00005144, 3'd0, 3, 2, 64, 0, 5, 2016, 0};
    vecs[1] = '{24'o33333333, 3'd3, 2, 1, 64, 0, 17, 2016, 0};
    vecs[2] = '{24'o77777770, 3'd7, 0, 3, 64, 1, 1, 16320, 0};
    vecs[3] = '{24'o00000002, 3'd0, 1, 2, 10, 0, 2, 45, 1};
    vecs[4] = '{24'o07654321, 3'd0, 4, 4, 66, 0, 8, 2016, 0};
    vecs[5] = '{24'o00000006, 3'd0, 6, 1, 0, 0, 2, 0, 1};

    reset = 1'b1; busy = 1'b0; done = 1'b0; IRB_RW = 1'b1; IRB_A = '0; IRB_D = '0; CROM_Q = '0;
    #1 reset = 1'b0;
    #2 check("reset_outputs", 32'({CROM_EN, CROM_A, cmd, cmd_valid, seq_done, checksum, err}), 0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 64; i++)
        rom[i] = (i < 8) ? vecs[k].head[3*i +: 3] : ((i < NUM_CMD) ? vecs[k].fill : 3'($urandom));
      busy_len = vecs[k].busy_len; gap = vecs[k].gap; n_wr = vecs[k].n_wr;
      for (int i = 0; i < 80; i++) data[i] = (vecs[k].dmode == 0) ? (i & 255) : 255;
      run_scen($sformatf("vec%0d", k), vecs[k].exp_pulses, vecs[k].exp_sum, vecs[k].exp_err, 0);
    end

    // busy stuck high: err/seq_done exactly TIMEOUT cycles after first WAIT_RDY entry
    for (int i = 0; i < 64; i++) rom[i] = 3'd4;
    do_reset();
    busy = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (CROM_EN === 1'b1) seen = 1'b1;
    end
    check("tmo fetch_seen", 32'(seen), 1);
    pulses = 0;
    repeat (TIMEOUT + 1) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0) pulses++;
    end
    check("tmo early_done_err", 32'({seq_done, err}), 0);
    @(negedge clk);
    check("tmo seq_done", 32'(seq_done), 1);
    check("tmo err", 32'(err), 1);
    check("tmo pulses", pulses, 0);
    busy = 1'b0;

    // reset in the middle of the write-back
    for (int i = 0; i < 64; i++) rom[i] = 3'($urandom);
    rom[0] = 3'd5; rom[1] = 3'd0;
    busy_len = 2; gap = 1; n_wr = 64;
    for (int i = 0; i < 80; i++) data[i] = i & 255;
    run_scen("rstmid", 0, 0, 0, 20);
    check("rstmid partial_sum", 32'(checksum), 171);
    reset = 1'b0;
    #1 check("rstmid async_zero", 32'({CROM_EN, CROM_A, cmd, cmd_valid, seq_done, checksum, err}), 0);
    IRB_RW = 1'b1; done = 1'b0; busy = 1'b0;
    @(negedge clk);
    check("rstmid held_zero", 32'({CROM_EN, CROM_A, cmd, cmd_valid, seq_done, checksum, err}), 0);
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(negedge clk);
      if (CROM_EN === 1'b1) begin
        seen = 1'b1;
        check("rstmid first_addr", 32'(CROM_A), 0);
      end
    end
    check("rstmid refetch", 32'(seen), 1);

    // randomized lists, stalls and write-back streams against the reference model
    for (int s = 0; s < 20; s++) begin
      for (int i = 0; i < 64; i++) begin
        v = $urandom_range(0, 15);
        rom[i] = (v < 2) ? 3'd0 : 3'(1 + v % 7);
      end
      busy_len = $urandom_range(0, 6);
      gap      = $urandom_range(1, 4);
      v        = $urandom_range(0, 9);
      n_wr     = (v < 6) ? 64 : ((v < 8) ? $urandom_range(0, 63) : $urandom_range(65, 66));
      for (int i = 0; i < 80; i++) data[i] = $urandom_range(0, 255);
      mq = model_cmds();
      run_scen($sformatf("rnd%0d", s), mq.size(), model_sum(), (n_wr < 64) ? 1 : 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
